// File: rtl/ifft4_seq.sv
// ifft4_seq: sequential 4-point inverse DFT, one time-shared radix-2 butterfly with conjugate twiddles
module ifft4_seq #(
  parameter int N = 3,
  parameter int SHFT = 0,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_i,
  output logic         out_last
);
  typedef enum logic [2:0] {LOAD, S1A, S1B, S2A, S2B, OUT} state_t;
  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d, a, b, ro, rn, nidx;
  logic [W-1:0] rr_q [4];
  logic [W-1:0] rr_d [4];
  logic [W-1:0] ri_q [4];
  logic [W-1:0] ri_d [4];
  logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [W-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic         twid;
  logic [W-1:0] pr, pi, qr, qi;
  logic [W:0]   tqr, tqi, sum_r, sum_i, dif_r, dif_i;

  // Bring a (W+1)-bit stage result back to W bits: halve, or clamp on overflow.
  function automatic logic [W-1:0] fit(input logic [W:0] v);
    if (SHFT != 0) return v[W:1];
    return (v[W] != v[W-1]) ? {v[W], {(W-1){~v[W]}}} : v[W-1:0];
  endfunction

  // Butterfly operand selection for the current stage; +i twiddle maps q to (-q_i, q_r).
  always_comb begin
    a     = (state_q == S1B) ? 2'd1 : (state_q == S2B) ? 2'd2 : 2'd0;
    b     = (state_q == S1A) ? 2'd2 : (state_q == S2A) ? 2'd1 : 2'd3;
    twid  = (state_q == S2B);
    pr    = rr_q[a];
    pi    = ri_q[a];
    qr    = rr_q[b];
    qi    = ri_q[b];
    tqr   = twid ? -{qi[W-1], qi} : {qr[W-1], qr};
    tqi   = twid ? {qr[W-1], qr} : {qi[W-1], qi};
    sum_r = {pr[W-1], pr} + tqr;
    sum_i = {pi[W-1], pi} + tqi;
    dif_r = {pr[W-1], pr} - tqr;
    dif_i = {pi[W-1], pi} - tqi;
  end

  // Next-state logic: load, four in-place butterflies, then bit-reversed readout.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    ri_d        = ri_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    nidx        = idx_q + 2'd1;
    ro          = {idx_q[0], idx_q[1]};
    rn          = {nidx[0], nidx[1]};
    case (state_q)
      LOAD: if (in_valid) begin
        rr_d[idx_q] = in_r;
        ri_d[idx_q] = in_i;
        idx_d       = nidx;
        state_d     = (idx_q == 2'd3) ? S1A : LOAD;
      end
      S1A, S1B, S2A, S2B: begin
        rr_d[a] = fit(sum_r);
        ri_d[a] = fit(sum_i);
        rr_d[b] = fit(dif_r);
        ri_d[b] = fit(dif_i);
        state_d = (state_q == S1A) ? S1B : (state_q == S1B) ? S2A : (state_q == S2A) ? S2B : OUT;
      end
      OUT: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_r_d     = rr_q[ro];
        out_i_d     = ri_q[ro];
        out_last_d  = (idx_q == 2'd3);
      end else if (out_ready) begin
        if (idx_q == 2'd3) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          idx_d       = 2'd0;
          state_d     = LOAD;
        end else begin
          idx_d      = nidx;
          out_r_d    = rr_q[rn];
          out_i_d    = ri_q[rn];
          out_last_d = (nidx == 2'd3);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= 2'd0;
      rr_q        <= '{default: '0};
      ri_q        <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      ri_q        <= ri_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
endmodule

// File: tb/tb_ifft4_seq.sv
// tb_ifft4_seq: directed checks of the 4-point inverse DFT engine (unscaled and halving instances)
module tb_ifft4_seq;
  logic       clk, rst_n, in_valid, out_ready;
  logic [7:0] in_r, in_i;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_r, out_i;
  logic       in_ready_b, out_valid_b, out_last_b;
  logic [7:0] out_r_b, out_i_b;
  int  total = 0, bad = 0;
  int  fr_r [4];
  int  fr_i [4];
  int  got_r [4];
  int  got_i [4];
  int  got_rb [4];
  int  got_ib [4];
  bit  got_l [4];
  time t_acc, t_ov;

  ifft4_seq #(.N(3), .SHFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_last(out_last));

  ifft4_seq #(.N(3), .SHFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_r(out_r_b), .out_i(out_i_b), .out_last(out_last_b));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic send(input int max_gap);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      @(negedge clk);
      in_valid = 1; in_r = 8'(fr_r[k]); in_i = 8'(fr_i[k]);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL send_timeout sample %0d in_ready=%0b want 1", k, in_ready); end
      @(posedge clk);
      t_acc = $time;
      #1 in_valid = 0;
    end
  endtask

  task automatic collect(input int stall_k);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL collect_timeout sample %0d out_valid=%0b want 1", k, out_valid); end
      if (k == 0) t_ov = $time;
      if (k == stall_k) begin
        logic [7:0] hr, hi;
        hr = out_r; hi = out_i;
        out_ready = 0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          total++;
          if (!out_valid || out_r !== hr || out_i !== hi || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold cyc %0d got v=%0b (%0d,%0d) in_ready=%0b want v=1 (%0d,%0d) in_ready=0",
                     s, out_valid, $signed(out_r), $signed(out_i), in_ready, $signed(hr), $signed(hi));
          end
        end
        out_ready = 1;
      end
      got_r[k] = $signed(out_r);  got_i[k] = $signed(out_i);  got_l[k] = out_last;
      got_rb[k] = $signed(out_r_b); got_ib[k] = $signed(out_i_b);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 0; in_r = 0; in_i = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 0 || out_last !== 0 || out_r !== 0 || out_i !== 0) begin
      bad++; $display("FAIL reset_outputs got v=%0b l=%0b r=%0d i=%0d want all 0", out_valid, out_last, out_r, out_i);
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if (in_ready !== 1 || out_valid !== 0) begin
      bad++; $display("FAIL reset_release got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_impulse;
    int er [4] = '{1, 1, 1, 1};
    fr_r = '{1, 0, 0, 0}; fr_i = '{0, 0, 0, 0};
    send(0); collect(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_r[k] !== er[k] || got_i[k] !== 0 || got_l[k] !== (k == 3)) begin
        bad++; $display("FAIL impulse[%0d] got (%0d,%0d,last=%0b) want (%0d,0,last=%0b)", k, got_r[k], got_i[k], got_l[k], er[k], k == 3);
      end
    end
    total++;
    if (t_ov - t_acc !== 55) begin
      bad++; $display("FAIL impulse_latency got %0t want 55 (valid 5 edges after last accept)", t_ov - t_acc);
    end
  endtask

  task automatic test_dc;
    int er [4] = '{40, 0, 0, 0};
    fr_r = '{10, 10, 10, 10}; fr_i = '{0, 0, 0, 0};
    send(0); collect(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_r[k] !== er[k] || got_i[k] !== 0 || got_l[k] !== (k == 3)) begin
        bad++; $display("FAIL dc[%0d] got (%0d,%0d,last=%0b) want (%0d,0,last=%0b)", k, got_r[k], got_i[k], got_l[k], er[k], k == 3);
      end
    end
  endtask

  task automatic test_tone(input int max_gap, input int stall_k);
    int er [4] = '{16, 0, -16, 0};
    int ei [4] = '{0, 16, 0, -16};
    fr_r = '{0, 16, 0, 0}; fr_i = '{0, 0, 0, 0};
    send(max_gap); collect(stall_k);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_r[k] !== er[k] || got_i[k] !== ei[k] || got_l[k] !== (k == 3)) begin
        bad++; $display("FAIL tone[%0d] got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", k, got_r[k], got_i[k], got_l[k], er[k], ei[k], k == 3);
      end
    end
  endtask

  task automatic test_saturation;
    int er [4] = '{127, 0, 0, 0};
    int ei [4] = '{-128, 0, 0, 0};
    int hr [4] = '{100, 0, 0, 0};
    int hi [4] = '{-100, 0, 0, 0};
    fr_r = '{100, 100, 100, 100}; fr_i = '{-100, -100, -100, -100};
    send(0); collect(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_r[k] !== er[k] || got_i[k] !== ei[k]) begin
        bad++; $display("FAIL sat[%0d] got (%0d,%0d) want (%0d,%0d)", k, got_r[k], got_i[k], er[k], ei[k]);
      end
      total++;
      if (got_rb[k] !== hr[k] || got_ib[k] !== hi[k]) begin
        bad++; $display("FAIL shift[%0d] got (%0d,%0d) want (%0d,%0d)", k, got_rb[k], got_ib[k], hr[k], hi[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    test_dc();
    @(negedge clk);
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL frame_end got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    test_tone(0, -1);
  endtask

  task automatic test_reset_midop;
    fr_r = '{100, 50, -30, 7}; fr_i = '{-100, 20, 5, 9};
    send(0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL midop_reset got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL midop_release got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    test_tone(0, -1);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_tone(0, -1);
    test_saturation();
    test_tone(3, 1);
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
